// File: rtl/pixel_streamer.sv
`default_nettype none
// =============================================================================
// Module   : pixel_streamer
// Purpose  : Raster-order int8 pixel source reading an SRAM, optional zero border
// Revision : 1.0 - initial release
// =============================================================================
module pixel_streamer #(
  parameter int IMG_W  = 96,
  parameter int IMG_H  = 96,
  parameter int PAD    = 0,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     stall,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [7:0]        mem_rd_data,
  output logic signed [7:0]        pixel_out,
  output logic                     valid_out,
  output logic                     busy,
  output logic                     done
);

  localparam int C_WP = IMG_W + 2*PAD;
  localparam int C_HP = IMG_H + 2*PAD;
  // One spare count so the unpadded right/bottom edge constants always fit.
  localparam int C_CW = $clog2(C_WP + 1);
  localparam int C_RW = $clog2(C_HP + 1);
  localparam logic [C_CW-1:0] C_COL_LAST = C_CW'(C_WP - 1);
  localparam logic [C_RW-1:0] C_ROW_LAST = C_RW'(C_HP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [C_CW-1:0]       r_col;
  logic [C_RW-1:0]       r_row;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W-1:0]     r_last_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_s1_vld;
  logic                  r_s1_pad;
  logic signed [7:0]     r_pixel;
  logic                  r_valid;

  logic                  w_pad;
  logic                  w_issue;
  logic                  w_rd;
  logic                  w_last;

  generate
    if (PAD == 0) begin : g_nopad
      assign w_pad = 1'b0;
    end else begin : g_pad
      localparam logic [C_CW-1:0] C_COL_LO = C_CW'(PAD);
      localparam logic [C_CW-1:0] C_COL_HI = C_CW'(IMG_W + PAD);
      localparam logic [C_RW-1:0] C_ROW_LO = C_RW'(PAD);
      localparam logic [C_RW-1:0] C_ROW_HI = C_RW'(IMG_H + PAD);
      assign w_pad = (r_col < C_COL_LO) || (r_col >= C_COL_HI) ||
                     (r_row < C_ROW_LO) || (r_row >= C_ROW_HI);
    end
  endgenerate

  assign w_issue   = (r_state == S_ISSUE) && !stall;
  assign w_rd      = w_issue && !w_pad;
  assign w_last    = (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);
  assign mem_rd_en = w_rd;
  // Pad issues leave the address bus parked on the last real read.
  assign mem_addr  = w_rd ? r_rd_ptr : r_last_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_rd_ptr    <= '0;
      r_last_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_ISSUE;
            r_col    <= '0;
            r_row    <= '0;
            r_rd_ptr <= base_addr;
            r_busy   <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            if (w_rd) begin
              r_rd_ptr    <= r_rd_ptr + 1'b1;
              r_last_addr <= r_rd_ptr;
            end
            if (w_last) begin
              r_state <= S_DRAIN;
              r_col   <= '0;
              r_row   <= '0;
            end else if (r_col == C_COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Stay here through the done cycle so a start coincident with done is ignored.
          if (r_done) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_s1_vld) begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_vld <= 1'b0;
      r_s1_pad <= 1'b0;
      r_pixel  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_s1_vld <= w_issue;
      r_s1_pad <= w_pad;
      r_valid  <= r_s1_vld;
      if (r_s1_vld) begin
        r_pixel <= r_s1_pad ? 8'sd0 : mem_rd_data;
      end
    end
  end

  assign pixel_out = r_pixel;
  assign valid_out = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_streamer.sv
`default_nettype none
// =============================================================================
// Module   : tb_pixel_streamer
// Purpose  : Self-checking bench: PAD=0 and PAD=1 instances against a frame model
// Revision : 1.0 - initial release
// =============================================================================
module tb_pixel_streamer;

  localparam int IW = 4;
  localparam int IH = 4;
  localparam int AW = 8;

  typedef struct {
    int base; int sfrom; int slen; int poke; int mode;
    int e_v0; int e_v1; int e_rd0; int e_rd1;
    int e_first0; int e_faddr; int e_laddr; int e_span0; int e_done0;
  } vec_t;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              stall;
  logic [AW-1:0]     base_addr;
  logic              a_rd    [2];
  logic [AW-1:0]     a_addr  [2];
  logic signed [7:0] a_rdata [2];
  logic signed [7:0] a_pix   [2];
  logic              a_vo    [2];
  logic              a_busy  [2];
  logic              a_done  [2];
  logic signed [7:0] mem [0:255];

  pixel_streamer #(.IMG_W(IW), .IMG_H(IH), .PAD(0), .ADDR_W(AW)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .stall(stall),
    .mem_rd_en(a_rd[0]), .mem_addr(a_addr[0]), .mem_rd_data(a_rdata[0]),
    .pixel_out(a_pix[0]), .valid_out(a_vo[0]), .busy(a_busy[0]), .done(a_done[0])
  );

  pixel_streamer #(.IMG_W(IW), .IMG_H(IH), .PAD(1), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .stall(stall),
    .mem_rd_en(a_rd[1]), .mem_addr(a_addr[1]), .mem_rd_data(a_rdata[1]),
    .pixel_out(a_pix[1]), .valid_out(a_vo[1]), .busy(a_busy[1]), .done(a_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) if (a_rd[d]) a_rdata[d] <= mem[a_addr[d]];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Frame model: coordinate index n walks the padded raster; outputs appear two cycles later.
  int m_busy[2], m_iss[2], m_n[2], m_base[2], m_last[2];
  int s1_v[2], s1_pad[2], s1_last[2], s1_addr[2];
  int e_v[2], e_p[2], e_done[2];
  int vcnt[2], rdcnt[2], dcnt[2], acc[2], fvc[2], lvc[2], faddr[2], laddr[2];
  int stream[2][64];
  int t_wp, t_tot, t_c, t_r, t_a, t_iss, t_pad, t_rd, t_busy, t_nd;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_busy[d] = 0; m_iss[d] = 0; m_n[d] = 0; m_last[d] = 0;
        s1_v[d] = 0; s1_pad[d] = 0; s1_last[d] = 0; s1_addr[d] = 0;
        e_v[d] = 0; e_p[d] = 0; e_done[d] = 0;
      end
      t_wp  = IW + 2*d;
      t_tot = t_wp * (IH + 2*d);
      t_iss = (m_iss[d] != 0 && !stall && reset_n) ? 1 : 0;
      t_pad = 0; t_rd = 0; t_a = m_last[d];
      if (t_iss != 0) begin
        t_c = m_n[d] % t_wp;
        t_r = m_n[d] / t_wp;
        t_pad = (t_c < d || t_c >= IW + d || t_r < d || t_r >= IH + d) ? 1 : 0;
        if (t_pad == 0) begin
          t_rd = 1;
          t_a  = m_base[d] + (t_r - d) * IW + (t_c - d);
        end
      end
      chk("mem_rd_en", d, a_rd[d], t_rd);
      chk("mem_addr", d, a_addr[d], t_a);
      chk("valid_out", d, a_vo[d], e_v[d]);
      chk("pixel_out", d, a_pix[d], e_p[d]);
      chk("done", d, a_done[d], e_done[d]);
      chk("busy", d, a_busy[d], m_busy[d]);
      if (reset_n) begin
        if (a_vo[d]) begin
          if (vcnt[d] < 64) stream[d][vcnt[d]] = a_pix[d];
          if (vcnt[d] == 0) fvc[d] = cyc;
          lvc[d] = cyc;
          vcnt[d]++;
        end
        if (a_rd[d]) begin
          if (rdcnt[d] == 0) faddr[d] = a_addr[d];
          laddr[d] = a_addr[d];
          rdcnt[d]++;
        end
        if (a_done[d]) dcnt[d]++;
        t_busy = m_busy[d];
        t_nd   = (s1_v[d] != 0 && s1_last[d] != 0) ? 1 : 0;
        if (s1_v[d] != 0) e_p[d] = (s1_pad[d] != 0) ? 0 : int'(mem[s1_addr[d]]);
        e_v[d] = s1_v[d];
        if (t_busy != 0 && e_done[d] != 0) m_busy[d] = 0;
        e_done[d]  = t_nd;
        s1_v[d]    = t_iss;
        s1_pad[d]  = t_pad;
        s1_addr[d] = t_a;
        s1_last[d] = (t_iss != 0 && m_n[d] == t_tot - 1) ? 1 : 0;
        if (t_iss != 0) begin
          if (t_rd != 0) m_last[d] = t_a;
          m_n[d]++;
          if (m_n[d] == t_tot) m_iss[d] = 0;
        end
        if (t_busy == 0 && start) begin
          m_busy[d] = 1; m_iss[d] = 1; m_n[d] = 0; m_base[d] = base_addr;
          if (acc[d] < 0) acc[d] = cyc;
        end
      end
    end
  end

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      vcnt[d] = 0; rdcnt[d] = 0; dcnt[d] = 0; acc[d] = -1;
      fvc[d] = 0; lvc[d] = 0; faddr[d] = 0; laddr[d] = 0;
    end
  endtask

  task automatic preload(input int b, input int poke, input int rnd);
    for (int i = 0; i < IW*IH; i++) begin
      if (rnd != 0) mem[b+i] = 8'($urandom_range(0, 255));
      else          mem[b+i] = 8'(i + 1);
    end
    if (poke != 0) mem[b] = -8'sd128;
  endtask

  // mode: 0 plain, 1 stray starts, 2 stray starts + restart after done, 3 reset after pixel 7, 4 random stall
  task automatic run_frame(input int b, input int sfrom, input int slen, input int mode);
    bit restarted, did_rst, st, fin;
    int j;
    restarted = 0; did_rst = 0; fin = 0; j = 0;
    clear_stats();
    @(posedge clk); #1;
    base_addr = AW'(b); start = 1'b1; stall = 1'b0;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(posedge clk); #1;
      j++;
      reset_n = 1'b1;
      st = 0;
      if ((mode == 1 || mode == 2) && (j == 10 || e_done[0] != 0)) st = 1;
      if (mode == 2 && dcnt[0] == 1 && !restarted) begin st = 1; restarted = 1; end
      if (mode == 3 && !did_rst && vcnt[0] == 7) begin reset_n = 1'b0; did_rst = 1; end
      if (mode == 4) stall = ($urandom_range(0, 2) == 0);
      else           stall = (j >= sfrom && j < sfrom + slen);
      start = st;
      if (!st && reset_n && m_busy[0] == 0 && m_busy[1] == 0) fin = 1;
    end
    start = 1'b0; stall = 1'b0; reset_n = 1'b1;
    if (!fin) chk("frame_timeout", 0, 0, 1);
  endtask

  vec_t tbl [6];
  int row1 [6];
  int row4 [6];

  initial begin
    tbl[0] = '{0,   0, 0, 0, 0, 16, 36, 16, 16,    1,   0,  15, 16, 1};
    tbl[1] = '{0,   6, 3, 0, 0, 16, 36, 16, 16,    1,   0,  15, 19, 1};
    tbl[2] = '{100, 0, 0, 1, 0, 16, 36, 16, 16, -128, 100, 115, 16, 1};
    tbl[3] = '{37,  2, 1, 0, 0, 16, 36, 16, 16,    1,  37,  52, 17, 1};
    tbl[4] = '{0,   0, 0, 0, 1, 16, 36, 16, 16,    1,   0,  15, 16, 1};
    tbl[5] = '{0,   0, 0, 0, 2, 32, 36, 32, 16,    1,   0,  15, 35, 2};
    row1 = '{0, 1, 2, 3, 4, 0};
    row4 = '{0, 13, 14, 15, 16, 0};

    for (int i = 0; i < 256; i++) mem[i] = 8'sd0;
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; base_addr = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      preload(tbl[i].base, tbl[i].poke, 0);
      run_frame(tbl[i].base, tbl[i].sfrom, tbl[i].slen, tbl[i].mode);
      chk("vcnt", 0, vcnt[0], tbl[i].e_v0);
      chk("vcnt", 1, vcnt[1], tbl[i].e_v1);
      chk("rdcnt", 0, rdcnt[0], tbl[i].e_rd0);
      chk("rdcnt", 1, rdcnt[1], tbl[i].e_rd1);
      chk("first_pixel", 0, stream[0][0], tbl[i].e_first0);
      chk("first_addr", 0, faddr[0], tbl[i].e_faddr);
      chk("last_addr", 0, laddr[0], tbl[i].e_laddr);
      chk("valid_span", 0, lvc[0] - fvc[0] + 1, tbl[i].e_span0);
      chk("done_count", 0, dcnt[0], tbl[i].e_done0);
      chk("done_count", 1, dcnt[1], 1);
      chk("start_latency", 0, fvc[0] - acc[0], 3);
      chk("start_latency", 1, fvc[1] - acc[1], 3);
      if (tbl[i].poke == 0) begin
        for (int p = 0; p < tbl[i].e_v0; p++) chk("stream_order", 0, stream[0][p], (p % 16) + 1);
        for (int p = 0; p < 6; p++) begin
          chk("pad_row0", 1, stream[1][p], 0);
          chk("pad_row1", 1, stream[1][6+p], row1[p]);
          chk("pad_row4", 1, stream[1][24+p], row4[p]);
          chk("pad_row5", 1, stream[1][30+p], 0);
        end
      end
    end

    preload(0, 0, 0);
    run_frame(0, 0, 0, 3);
    chk("rst_vcnt", 0, vcnt[0], 7);
    chk("rst_reads", 0, rdcnt[0], 9);
    chk("rst_reads", 1, rdcnt[1], 2);
    chk("rst_valid", 0, a_vo[0], 0);
    chk("rst_pixel", 0, a_pix[0], 0);
    chk("rst_busy", 0, a_busy[0], 0);
    repeat (5) @(posedge clk);
    chk("rst_no_reads", 0, rdcnt[0], 9);
    run_frame(0, 0, 0, 0);
    chk("post_rst_vcnt", 0, vcnt[0], 16);
    for (int p = 0; p < 16; p++) chk("post_rst_stream", 0, stream[0][p], p + 1);

    for (int i = 0; i < 5; i++) begin
      int b;
      b = int'($urandom_range(0, 200));
      preload(b, 0, 1);
      run_frame(b, 0, 0, 4);
      chk("rnd_vcnt", 0, vcnt[0], 16);
      chk("rnd_vcnt", 1, vcnt[1], 36);
      chk("rnd_rdcnt", 0, rdcnt[0], 16);
      chk("rnd_rdcnt", 1, rdcnt[1], 16);
      chk("rnd_done", 0, dcnt[0], 1);
      chk("rnd_first_addr", 0, faddr[0], b);
      chk("rnd_last_addr", 1, laddr[1], b + 15);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
